cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the single common data bus (CDB) between the execution units (ALU0, ALU1, LS, BRANCH).
//   Each unit raises a request with its result tag and data. It holds that request until granted.
//   One winner per cycle is chosen by round-robin, and its result is broadcast on a registered CDB.
//   All reservation stations snoop the CDB to wake tagged operands (tag_rx/tag_ry -> data).
// PARAMETERS
//   N_REQ   4   number of requesters; index 0=ALU0, 1=ALU1, 2=LS, 3=BRANCH
//   TAG_W   4   width of a register tag; all-ones = UNLOCKED (no producer)
//   DATA_W  32  result word width
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   rst_n      in   1             synchronous reset, active-low
//   rdy        in   1             global enable; 0 = freeze all state, no grants
//   flush      in   1             pipeline flush (branch mispredict); drop bus and grants
//   req        in   N_REQ         per-unit result-valid request, held until granted
//   req_tag    in   N_REQ*TAG_W   per-unit destination tag, slice i = unit i
//   req_data   in   N_REQ*DATA_W  per-unit result data, slice i = unit i
//   gnt        out  N_REQ         one-hot grant, combinational, same cycle as winning req
//   cdb_valid  out  1             registered: CDB carries a result this cycle
//   cdb_tag    out  TAG_W         registered: broadcast tag
//   cdb_data   out  DATA_W        registered: broadcast data
//   cdb_src    out  clog2(N_REQ)  registered: index of winning unit
//   err        out  1             sticky: a request with tag==UNLOCKED was seen
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): cdb_valid=0, cdb_tag=all-ones, cdb_data=0, cdb_src=0,
//     ptr=0, err=0. gnt=0 while rst_n=0.
//   Grant (combinational): active only when rst_n=1, rdy=1 and flush=0.
//     Scan req from ptr upward, wrapping N_REQ-1 -> 0. The first set bit wins and gnt is one-hot.
//     No grant when no req is set, or when rdy=0 or flush=1.
//   Handshake: unit i keeps req/tag/data stable until it sees gnt[i]=1 at a posedge.
//     It may drop req or present a new result in the following cycle.
//   CDB register (posedge, rdy=1): a grant to w loads cdb_valid=1, cdb_tag=req_tag[w],
//     cdb_data=req_data[w] and cdb_src=w. Latency is 1 cycle from grant to bus.
//     With no grant, cdb_valid<=0; tag is set to all-ones and data/src hold.
//   ptr (posedge, rdy=1): on a grant to w, ptr <= (w+1) mod N_REQ. With no grant, ptr holds.
//   Fairness: a continuously held req is granted within N_REQ cycles of rdy=1 and flush=0.
//   rdy=0: every register holds, including cdb_valid. gnt=0, so requesters keep waiting.
//   flush=1 (rdy=1): cdb_valid<=0 and cdb_tag<=all-ones at the next posedge, with no grant.
//     ptr holds. A result latched in the cycle before the flush still broadcasts for its one cycle.
//   Simultaneous rst_n=0 with flush or rdy=0: reset wins.
//   A reset during a held request leaves the requester's req untouched. The requester is
//     reset by the same rst_n.
//   A req with tag==UNLOCKED is excluded from arbitration and sets err=1, which stays set
//     until reset. err updates only when rdy=1.
//   Width rules: gnt is strictly one-hot or zero. cdb_src is clog2(N_REQ) bits (2 at default).
// TESTING
//   1 Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, cdb_valid=0, cdb_tag=4'hF,
//     err=0.
//   2 Single request: req=4'b0100, tag=3, data=32'hDEADBEEF -> gnt=4'b0100 in the same cycle.
//     Next cycle cdb_valid=1, tag=3, data=DEADBEEF, src=2. The cycle after, cdb_valid=0.
//   3 Round-robin wrap: hold req=4'b1111 from ptr=0 -> cdb_src sequence 0,1,2,3,0.
//     cdb_valid stays 1 on consecutive cycles.
//   4 Fairness: ptr=3 with req=4'b1001, then req[1] rises.
//     -> grants go 3, 0, 1, each within 4 cycles.
//   5 Stall/flush: a granted result is followed by rdy=0 for 3 cycles -> cdb_* holds and gnt=0.
//     Then flush=1 for 1 cycle -> cdb_valid=0 with ptr unchanged. Requests resume from ptr.
//   6 Illegal tag: req=4'b0010 with tag=4'hF -> no grant, err=1 next cycle, and err stays 1
//     until rst_n=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one execution-unit result per cycle
// and broadcasts it on a registered CDB one cycle after the combinational grant.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(N_REQ)-1:0]   cdb_src,
  output logic                       err,
  output logic [$clog2(N_REQ)-1:0]   dbg_ptr
);

  // Handshake: unit i holds req[i]/tag/data stable until it sees gnt[i]=1 at a posedge;
  // the granted result appears on cdb_* (cdb_valid=1) in the following cycle.

  localparam int               SRC_W    = $clog2(N_REQ);
  localparam logic [TAG_W-1:0] UNLOCKED = '1;

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  legal;
  logic [N_REQ-1:0]  illegal;
  logic              arb_en;
  logic              found;
  logic [SRC_W-1:0]  win;

  // A request carrying the UNLOCKED tag has no destination and must never reach the bus.
  always_comb begin
    legal   = '0;
    illegal = '0;
    for (int i = 0; i < N_REQ; i++) begin
      legal[i]   = req[i] && (req_tag[i*TAG_W +: TAG_W] != UNLOCKED);
      illegal[i] = req[i] && (req_tag[i*TAG_W +: TAG_W] == UNLOCKED);
    end
  end

  assign arb_en = rst_n && rdy && !flush;

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (arb_en && !found && legal[idx]) begin
        found    = 1'b1;
        win      = SRC_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = UNLOCKED;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    err_d       = err_q | (|illegal);
    if (found) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = req_tag[int'(win)*TAG_W +: TAG_W];
      cdb_data_d  = req_data[int'(win)*DATA_W +: DATA_W];
      cdb_src_d   = win;
      ptr_d       = (win == SRC_W'(N_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  // rdy=0 freezes everything, including a result already on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= UNLOCKED;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      err_q       <= 1'b0;
    end else if (rdy) begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      err_q       <= err_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign err       = err_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants are checked in-cycle, broadcasts are checked
// by a monitor against a queue of results expected from each grant.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n, rdy, flush;
  logic [3:0]   req;
  logic [15:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;
  logic         err;
  logic [1:0]   dbg_ptr;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic        rdy_seen = 1'b0;

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .req(req), .req_tag(req_tag), .req_data(req_data),
    .gnt(gnt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .err(err), .dbg_ptr(dbg_ptr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_unit(input int i, input logic [3:0] tag, input logic [31:0] data);
    req_tag[i*4 +: 4]    = tag;
    req_data[i*32 +: 32] = data;
  endtask

  // One clock: check the combinational grant mid-cycle, queue the broadcast it implies.
  task automatic cycle(input logic [3:0] exp_gnt);
    @(negedge clk);
    check("gnt", {60'd0, gnt}, {60'd0, exp_gnt});
    for (int i = 0; i < 4; i++)
      if (exp_gnt[i]) exp_q.push_back({2'(i), req_tag[i*4 +: 4], req_data[i*32 +: 32]});
    @(posedge clk);
    #1;
  endtask

  // monitor: a fresh broadcast exists only after a posedge with rdy=1 out of reset
  always @(posedge clk) rdy_seen <= rst_n && rdy;

  always @(negedge clk) begin
    if (rdy_seen && cdb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got %0h expected none", {cdb_src, cdb_tag, cdb_data});
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("cdb_bcast", {26'd0, cdb_src, cdb_tag, cdb_data}, {26'd0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    req = 4'b1111; req_tag = 16'h3210; req_data = '0;
    @(posedge clk); #1;

    // 1: reset with all requests raised
    cycle(4'b0000);
    cycle(4'b0000);
    check("rst_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_tag", {60'd0, cdb_tag}, 64'hF);
    check("rst_data", {32'd0, cdb_data}, 64'd0);
    check("rst_src", {62'd0, cdb_src}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_ptr", {62'd0, dbg_ptr}, 64'd0);
    rst_n = 1'b1; req = 4'b0000;

    // 2: single request from LS
    set_unit(2, 4'd3, 32'hDEADBEEF);
    req = 4'b0100;
    cycle(4'b0100);
    req = 4'b0000;
    check("single_valid", {63'd0, cdb_valid}, 64'd1);
    check("single_tag", {60'd0, cdb_tag}, 64'd3);
    check("single_data", {32'd0, cdb_data}, 64'hDEADBEEF);
    check("single_src", {62'd0, cdb_src}, 64'd2);
    cycle(4'b0000);
    check("single_after_valid", {63'd0, cdb_valid}, 64'd0);
    check("single_after_tag", {60'd0, cdb_tag}, 64'hF);
    check("single_ptr", {62'd0, dbg_ptr}, 64'd3);

    // 3: bring ptr to 0, then all four held -> 0,1,2,3,0
    set_unit(3, 4'd9, 32'h1);
    req = 4'b1000;
    cycle(4'b1000);
    check("rr_ptr0", {62'd0, dbg_ptr}, 64'd0);
    for (int i = 0; i < 4; i++) set_unit(i, 4'(i + 4), 32'h1000_0000 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0001 << (k % 4));
      check("rr_valid", {63'd0, cdb_valid}, 64'd1);
      check("rr_src", {62'd0, cdb_src}, 64'(k % 4));
    end
    req = 4'b0000;
    cycle(4'b0000);
    check("rr_ptr_end", {62'd0, dbg_ptr}, 64'd1);

    // 4: fairness from ptr=3 with 1001, then req[1] rises
    set_unit(2, 4'd5, 32'h44);
    req = 4'b0100;
    cycle(4'b0100);
    check("fair_ptr3", {62'd0, dbg_ptr}, 64'd3);
    set_unit(0, 4'd6, 32'h50);
    set_unit(3, 4'd8, 32'h53);
    req = 4'b1001;
    cycle(4'b1000);
    set_unit(1, 4'd2, 32'h51);
    req = 4'b0011;
    cycle(4'b0001);
    req = 4'b0010;
    cycle(4'b0010);
    req = 4'b0000;
    cycle(4'b0000);
    check("fair_ptr_end", {62'd0, dbg_ptr}, 64'd2);

    // 5: stall holds the bus, flush clears it, ptr survives both
    set_unit(2, 4'd7, 32'hA5A5A5A5);
    req = 4'b0100;
    cycle(4'b0100);
    req = 4'b1000;
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000);
      check("stall_valid", {63'd0, cdb_valid}, 64'd1);
      check("stall_tag", {60'd0, cdb_tag}, 64'd7);
      check("stall_data", {32'd0, cdb_data}, 64'hA5A5A5A5);
      check("stall_src", {62'd0, cdb_src}, 64'd2);
      check("stall_ptr", {62'd0, dbg_ptr}, 64'd3);
    end
    rdy = 1'b1; flush = 1'b1;
    cycle(4'b0000);
    check("flush_valid", {63'd0, cdb_valid}, 64'd0);
    check("flush_tag", {60'd0, cdb_tag}, 64'hF);
    check("flush_src", {62'd0, cdb_src}, 64'd2);
    check("flush_ptr", {62'd0, dbg_ptr}, 64'd3);
    flush = 1'b0;
    cycle(4'b1000);
    req = 4'b0001;
    cycle(4'b0001);
    req = 4'b0000;
    cycle(4'b0000);
    check("resume_ptr", {62'd0, dbg_ptr}, 64'd1);

    // 6: UNLOCKED tag is never granted and latches err until reset
    set_unit(1, 4'hF, 32'hBAD);
    req = 4'b0010;
    cycle(4'b0000);
    check("ill_err", {63'd0, err}, 64'd1);
    check("ill_valid", {63'd0, cdb_valid}, 64'd0);
    set_unit(0, 4'd1, 32'h77);
    req = 4'b0011;
    cycle(4'b0001);
    req = 4'b0000;
    cycle(4'b0000);
    cycle(4'b0000);
    check("ill_err_sticky", {63'd0, err}, 64'd1);
    rst_n = 1'b0;
    cycle(4'b0000);
    check("ill_err_rst", {63'd0, err}, 64'd0);
    check("ill_ptr_rst", {62'd0, dbg_ptr}, 64'd0);
    rst_n = 1'b1;
    cycle(4'b0000);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
